mor1kx_branch_predictor_tournament: RTL

Parametrised successor to the fixed simple, saturation-counter and gshare predictors for the mor1kx cappuccino pipeline. Runs a bimodal table (indexed by PC) and a gshare table (PC XOR global history) side by side, and a per-PC chooser table picks which one predicts. Predicts in decode and resolves in execute. A post-reset sweep FSM initialises all tables; until the sweep finishes, a static backward-taken rule provides the prediction.

---
 rtl/mor1kx_bp_pkg.sv | 31 +++
 rtl/mor1kx_bp_counter_table.sv | 41 ++++
 rtl/mor1kx_branch_predictor_tournament.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/mor1kx_bp_pkg.sv
// Shared types and helpers for the tournament branch predictor.
// Provides the INIT/RUN state encoding, counter init values and saturating steps.
package mor1kx_bp_pkg;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } bp_state_e;

  // Weakly not-taken for a w-bit direction counter.
  function automatic logic [31:0] cnt_init(input int w);
    return (32'd1 << (w - 1)) - 32'd1;
  endfunction

  // Weakly favour bimodal for a w-bit chooser counter.
  function automatic logic [31:0] cho_init(input int w);
    return (32'd1 << (w - 1)) - 32'd1;
  endfunction

  function automatic logic [31:0] sat_inc(input logic [31:0] v,
                                          input int w);
    logic [31:0] mx;
    mx = (32'd1 << w) - 32'd1;
    return (v >= mx) ? mx : v + 32'd1;
  endfunction

  function automatic logic [31:0] sat_dec(input logic [31:0] v);
    return (v == 32'd0) ? 32'd0 : v - 32'd1;
  endfunction

endpackage

// File: rtl/mor1kx_bp_counter_table.sv
// Table of saturating counters: async read, saturating update, sweep init.
// Ports: raddr_i/rdata_o read, we_i/waddr_i/up_i step, sweep_we_i/sweep_addr_i init.
module mor1kx_bp_counter_table
  import mor1kx_bp_pkg::*;
#(
  parameter int DEPTH_LOG2 = 6,
  parameter int WIDTH      = 2,
  parameter int INIT_VAL   = 1
) (
  input  logic                  clk,
  input  logic [DEPTH_LOG2-1:0] raddr_i,
  output logic [WIDTH-1:0]      rdata_o,
  input  logic                  we_i,
  input  logic [DEPTH_LOG2-1:0] waddr_i,
  input  logic                  up_i,
  input  logic                  sweep_we_i,
  input  logic [DEPTH_LOG2-1:0] sweep_addr_i
);

  logic [WIDTH-1:0] mem_q [2**DEPTH_LOG2];
  logic [WIDTH-1:0] cur;
  logic [WIDTH-1:0] nxt;

  assign rdata_o = mem_q[raddr_i];
  assign cur     = mem_q[waddr_i];

  always_comb begin
    nxt = cur;
    if (up_i) nxt = WIDTH'(sat_inc(32'(cur), WIDTH));
    else      nxt = WIDTH'(sat_dec(32'(cur)));
  end

  // A same-cycle read of the written entry sees the old value.
  always_ff @(posedge clk) begin
    if (sweep_we_i)
      mem_q[sweep_addr_i] <= WIDTH'(INIT_VAL);
    else if (we_i)
      mem_q[waddr_i] <= nxt;
  end

endmodule

// File: rtl/mor1kx_branch_predictor_tournament.sv
// Tournament predictor: bimodal + gshare with per-PC chooser, decode predict, execute resolve.
// Ports: decode branch/PC in, execute resolve in, predicted_flag_o, branch_mispredict_o, init_busy_o.
module mor1kx_branch_predictor_tournament
  import mor1kx_bp_pkg::*;
#(
  parameter int OPTION_OPERAND_WIDTH = 32,
  parameter int BP_HISTORY_WIDTH     = 8,
  parameter int BP_LOCAL_INDEX_WIDTH = 6,
  parameter int BP_COUNTER_WIDTH     = 2,
  parameter int BP_CHOOSER_WIDTH     = 2
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            op_bf_i,
  input  logic                            op_bnf_i,
  input  logic [9:0]                      immjbr_upper_i,
  input  logic [OPTION_OPERAND_WIDTH-1:0] brn_pc_i,
  input  logic                            padv_decode_i,
  input  logic                            prev_op_brcond_i,
  input  logic                            prev_predicted_flag_i,
  input  logic                            flag_i,
  input  logic                            execute_bf_i,
  input  logic                            execute_bnf_i,
  output logic                            predicted_flag_o,
  output logic                            branch_mispredict_o,
  output logic                            init_busy_o
);

  localparam int HW  = BP_HISTORY_WIDTH;
  localparam int LW  = BP_LOCAL_INDEX_WIDTH;
  localparam int CW  = BP_COUNTER_WIDTH;
  localparam int XW  = BP_CHOOSER_WIDTH;
  localparam int SWW = (HW > LW) ? HW : LW;
  localparam int CNT_INIT = int'(cnt_init(CW));
  localparam int CHO_INIT = int'(cho_init(XW));

  bp_state_e      state_q, state_d;
  logic [SWW-1:0] sweep_q, sweep_d;
  logic [HW-1:0]  ghr_q, ghr_d;
  logic           pend_valid_q, pend_valid_d;
  logic [LW-1:0]  pend_bidx_q, pend_bidx_d;
  logic [HW-1:0]  pend_gidx_q, pend_gidx_d;
  logic           pend_bmsb_q, pend_bmsb_d;
  logic           pend_gmsb_q, pend_gmsb_d;

  logic [LW-1:0]  bidx;
  logic [HW-1:0]  gidx;
  logic [CW-1:0]  bim_rd, gsh_rd;
  logic [XW-1:0]  cho_rd;
  logic           run, sweep_we, sweep_last;
  logic           snap, upd, actual, taken_pred;
  logic           cho_we, cho_up;
  logic           unused_ok;

  assign bidx = brn_pc_i[LW+1:2];
  assign gidx = brn_pc_i[HW+1:2] ^ ghr_q;
  assign sweep_last = (sweep_q == '1);

  // State register and all sequential state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_INIT;
      sweep_q      <= '0;
      ghr_q        <= '0;
      pend_valid_q <= 1'b0;
      pend_bidx_q  <= '0;
      pend_gidx_q  <= '0;
      pend_bmsb_q  <= 1'b0;
      pend_gmsb_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      sweep_q      <= sweep_d;
      ghr_q        <= ghr_d;
      pend_valid_q <= pend_valid_d;
      pend_bidx_q  <= pend_bidx_d;
      pend_gidx_q  <= pend_gidx_d;
      pend_bmsb_q  <= pend_bmsb_d;
      pend_gmsb_q  <= pend_gmsb_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    if (state_q == ST_INIT && sweep_last)
      state_d = ST_RUN;
  end

  // State-decoded outputs.
  always_comb begin
    run         = (state_q == ST_RUN);
    init_busy_o = !run;
    sweep_we    = !run;
  end

  always_comb begin
    sweep_d = sweep_q;
    if (sweep_we) sweep_d = sweep_q + 1'b1;
  end

  always_comb begin
    if (!run)
      taken_pred = immjbr_upper_i[9];
    else if (cho_rd[XW-1])
      taken_pred = gsh_rd[CW-1];
    else
      taken_pred = bim_rd[CW-1];
  end

  always_comb begin
    predicted_flag_o = 1'b0;
    if (op_bf_i)       predicted_flag_o = taken_pred;
    else if (op_bnf_i) predicted_flag_o = !taken_pred;
  end

  assign branch_mispredict_o =
    prev_op_brcond_i & (flag_i != prev_predicted_flag_i);

  assign snap = padv_decode_i & (op_bf_i | op_bnf_i) & run;
  assign upd  = prev_op_brcond_i & padv_decode_i
              & pend_valid_q & run;
  assign actual = execute_bf_i ? flag_i : !flag_i;

  // The update always works on the old snapshot; a
  // same-cycle capture takes its index from the pre-shift ghr.
  always_comb begin
    pend_valid_d = pend_valid_q;
    pend_bidx_d  = pend_bidx_q;
    pend_gidx_d  = pend_gidx_q;
    pend_bmsb_d  = pend_bmsb_q;
    pend_gmsb_d  = pend_gmsb_q;
    ghr_d        = ghr_q;
    if (upd) begin
      pend_valid_d = 1'b0;
      ghr_d        = {ghr_q[HW-2:0], actual};
    end
    if (snap) begin
      pend_valid_d = 1'b1;
      pend_bidx_d  = bidx;
      pend_gidx_d  = gidx;
      pend_bmsb_d  = bim_rd[CW-1];
      pend_gmsb_d  = gsh_rd[CW-1];
    end
  end

  // Chooser only learns when the components disagreed.
  assign cho_we = upd & (pend_bmsb_q != pend_gmsb_q);
  assign cho_up = (pend_gmsb_q == actual);

  mor1kx_bp_counter_table #(
    .DEPTH_LOG2 (LW),
    .WIDTH      (CW),
    .INIT_VAL   (CNT_INIT)
  ) u_bim (
    .clk          (clk),
    .raddr_i      (bidx),
    .rdata_o      (bim_rd),
    .we_i         (upd),
    .waddr_i      (pend_bidx_q),
    .up_i         (actual),
    .sweep_we_i   (sweep_we),
    .sweep_addr_i (sweep_q[LW-1:0])
  );

  mor1kx_bp_counter_table #(
    .DEPTH_LOG2 (HW),
    .WIDTH      (CW),
    .INIT_VAL   (CNT_INIT)
  ) u_gsh (
    .clk          (clk),
    .raddr_i      (gidx),
    .rdata_o      (gsh_rd),
    .we_i         (upd),
    .waddr_i      (pend_gidx_q),
    .up_i         (actual),
    .sweep_we_i   (sweep_we),
    .sweep_addr_i (sweep_q[HW-1:0])
  );

  mor1kx_bp_counter_table #(
    .DEPTH_LOG2 (LW),
    .WIDTH      (XW),
    .INIT_VAL   (CHO_INIT)
  ) u_cho (
    .clk          (clk),
    .raddr_i      (bidx),
    .rdata_o      (cho_rd),
    .we_i         (cho_we),
    .waddr_i      (pend_bidx_q),
    .up_i         (cho_up),
    .sweep_we_i   (sweep_we),
    .sweep_addr_i (sweep_q[LW-1:0])
  );

  assign unused_ok = ^{brn_pc_i, immjbr_upper_i[8:0],
                       bim_rd, gsh_rd, cho_rd, execute_bnf_i};

endmodule
